// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer sequencing controller.
package countdown_pkg;

  localparam int STATE_W = 3;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_e;

  function automatic logic bcd_is_zero(input logic [3:0] hi, input logic [3:0] lo);
    return (hi == BCD_ZERO) && (lo == BCD_ZERO);
  endfunction

endpackage

// File: rtl/countdown_controller_if.sv
// Button, digit and strobe bundle between the controller and its neighbours.
// Buttons are single-cycle pulses; strobes are single-cycle registered pulses.
interface countdown_controller_if;
  import countdown_pkg::*;

  logic               start_btn;
  logic               pause_btn;
  logic               load_btn;
  logic               clear_btn;
  logic [3:0]         digit_lo;
  logic [3:0]         digit_hi;
  logic               timer_decrement_1sec;
  logic               reconfig_button;
  logic               timer_reset;
  logic               running;
  logic               expired;
  logic [STATE_W-1:0] state;

  modport master (
    output start_btn, pause_btn, load_btn, clear_btn, digit_lo, digit_hi,
    input  timer_decrement_1sec, reconfig_button, timer_reset, running, expired, state
  );

  modport slave (
    input  start_btn, pause_btn, load_btn, clear_btn, digit_lo, digit_hi,
    output timer_decrement_1sec, reconfig_button, timer_reset, running, expired, state
  );

endinterface

// File: rtl/countdown_controller_tick_prescaler.sv
// Divides clk down to one wrap pulse every TICK_DIV enabled cycles.
// The count holds while disabled so a paused partial second is preserved.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap;

  assign wrap = (cnt_q == LAST);
  assign tick = enable && !clear && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_controller.sv
// Countdown sequencing FSM: button priority, tick generation, expiry detection.
// Define CNTDN_AUTO_RELOAD_EN to reload and restart automatically on expiry.
module countdown_controller
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  countdown_controller_if.slave  bus
);

  state_e state_q, state_d;
  logic   tick_q, tick_d;
  logic   reconfig_q, reconfig_d;
  logic   treset_q, treset_d;
  logic   running_q, expired_q;
  logic   zero;
  logic   pre_en, pre_clr, pre_tick;
  logic   clr_sel, load_sel, pause_sel, start_sel;
`ifdef CNTDN_AUTO_RELOAD_EN
  logic   auto_q, auto_d;
`endif

  assign zero = bcd_is_zero(bus.digit_hi, bus.digit_lo);

  // Only the highest-priority pulse in a cycle is ever acted on.
  assign clr_sel   = bus.clear_btn;
  assign load_sel  = bus.load_btn  && !bus.clear_btn;
  assign pause_sel = bus.pause_btn && !bus.load_btn && !bus.clear_btn;
  assign start_sel = bus.start_btn && !bus.pause_btn && !bus.load_btn && !bus.clear_btn;

  always_comb begin
    state_d = state_q;
`ifdef CNTDN_AUTO_RELOAD_EN
    auto_d  = auto_q;
`endif
    if (clr_sel) begin
      state_d = ST_IDLE;
`ifdef CNTDN_AUTO_RELOAD_EN
      auto_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_sel)               state_d = ST_LOAD;
          else if (start_sel && !zero) state_d = ST_RUN;
        end
        ST_LOAD: begin
`ifdef CNTDN_AUTO_RELOAD_EN
          state_d = auto_q ? ST_RUN : ST_IDLE;
          auto_d  = 1'b0;
`else
          state_d = ST_IDLE;
`endif
        end
        ST_RUN: begin
          // Digits are stale while the decrement strobe is on the wire.
          if (pause_sel)              state_d = ST_PAUSE;
          else if (zero && !tick_q)   state_d = ST_EXPIRED;
        end
        ST_PAUSE: begin
          if (load_sel)               state_d = ST_LOAD;
          else if (start_sel && !zero) state_d = ST_RUN;
        end
        ST_EXPIRED: begin
`ifdef CNTDN_AUTO_RELOAD_EN
          state_d = ST_LOAD;
          auto_d  = !load_sel;
`else
          if (load_sel)               state_d = ST_LOAD;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Counting follows the next state so the first tick lands TICK_DIV cycles after start.
  assign pre_en  = (state_d == ST_RUN);
  assign pre_clr = !((state_d == ST_RUN) || (state_d == ST_PAUSE));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (pre_en),
    .clear  (pre_clr),
    .tick   (pre_tick)
  );

  assign tick_d     = pre_tick && !zero;
  assign reconfig_d = (state_d == ST_LOAD);
  assign treset_d   = clr_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_q     <= 1'b0;
      reconfig_q <= 1'b0;
      treset_q   <= 1'b0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      reconfig_q <= reconfig_d;
      treset_q   <= treset_d;
      running_q  <= (state_d == ST_RUN);
      expired_q  <= (state_d == ST_EXPIRED);
    end
  end

`ifdef CNTDN_AUTO_RELOAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_q <= 1'b0;
    end else begin
      auto_q <= auto_d;
    end
  end
`endif

  assign bus.timer_decrement_1sec = tick_q;
  assign bus.reconfig_button      = reconfig_q;
  assign bus.timer_reset          = treset_q;
  assign bus.running              = running_q;
  assign bus.expired              = expired_q;
  assign bus.state                = state_q;

endmodule

// File: tb/tb_countdown_controller.sv
// Directed bench for countdown_controller with TICK_DIV=4 and a behavioural BCD timer.
module tb_countdown_controller;

  localparam int TICK_DIV = 4;

  logic       clk;
  logic       rst;
  logic [7:0] set_val;
  logic [3:0] m_hi, m_lo;
  int         checks;
  int         errors;

  countdown_controller_if bus_if ();

  countdown_controller #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-digit BCD timer the controller drives.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= 4'd0;
      m_lo <= 4'd0;
    end else if (bus_if.timer_reset) begin
      m_hi <= 4'd0;
      m_lo <= 4'd0;
    end else if (bus_if.reconfig_button) begin
      m_hi <= set_val[7:4];
      m_lo <= set_val[3:0];
    end else if (bus_if.timer_decrement_1sec && !(m_hi == 4'd0 && m_lo == 4'd0)) begin
      if (m_lo == 4'd0) begin
        m_lo <= 4'd9;
        m_hi <= m_hi - 4'd1;
      end else begin
        m_lo <= m_lo - 4'd1;
      end
    end
  end

  assign bus_if.digit_hi = m_hi;
  assign bus_if.digit_lo = m_lo;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p, input logic l, input logic c);
    bus_if.start_btn = s;
    bus_if.pause_btn = p;
    bus_if.load_btn  = l;
    bus_if.clear_btn = c;
    step();
    bus_if.start_btn = 1'b0;
    bus_if.pause_btn = 1'b0;
    bus_if.load_btn  = 1'b0;
    bus_if.clear_btn = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick"},  8'(bus_if.timer_decrement_1sec), 8'h00);
    check({tag, "_rcfg"},  8'(bus_if.reconfig_button), 8'h00);
    check({tag, "_trst"},  8'(bus_if.timer_reset), 8'h00);
    check({tag, "_run"},   8'(bus_if.running), 8'h00);
    check({tag, "_exp"},   8'(bus_if.expired), 8'h00);
    check({tag, "_state"}, 8'(bus_if.state), 8'h00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    set_val = 8'h00;
    rst = 1'b1;
    bus_if.start_btn = 1'b0;
    bus_if.pause_btn = 1'b0;
    bus_if.load_btn  = 1'b0;
    bus_if.clear_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Load 02, then run it down to expiry.
    set_val = 8'h02;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("load1_rcfg", 8'(bus_if.reconfig_button), 8'h01);
    check("load1_state", 8'(bus_if.state), 8'h01);
    step();
    check("load1_idle", 8'(bus_if.state), 8'h00);
    check("load1_rcfg_off", 8'(bus_if.reconfig_button), 8'h00);
    check("load1_digits", {m_hi, m_lo}, 8'h02);

    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("run02_tick_c%0d", k), 8'(bus_if.timer_decrement_1sec),
            ((k == 4) || (k == 8)) ? 8'h01 : 8'h00);
      check($sformatf("run02_running_c%0d", k), 8'(bus_if.running), 8'h01);
      check($sformatf("run02_exp_c%0d", k), 8'(bus_if.expired), 8'h00);
      step();
    end
`ifdef CNTDN_AUTO_RELOAD_EN
    check("auto_expired", 8'(bus_if.expired), 8'h01);
    check("auto_exp_state", 8'(bus_if.state), 8'h04);
    step();
    check("auto_load_state", 8'(bus_if.state), 8'h01);
    check("auto_rcfg", 8'(bus_if.reconfig_button), 8'h01);
    check("auto_exp_pulse", 8'(bus_if.expired), 8'h00);
    step();
    check("auto_rerun_state", 8'(bus_if.state), 8'h02);
    check("auto_rerun_running", 8'(bus_if.running), 8'h01);
`else
    for (int k = 10; k <= 14; k++) begin
      check($sformatf("exp_flag_c%0d", k), 8'(bus_if.expired), 8'h01);
      check($sformatf("exp_state_c%0d", k), 8'(bus_if.state), 8'h04);
      check($sformatf("exp_running_c%0d", k), 8'(bus_if.running), 8'h00);
      check($sformatf("exp_notick_c%0d", k), 8'(bus_if.timer_decrement_1sec), 8'h00);
      step();
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("exp_load_state", 8'(bus_if.state), 8'h01);
    check("exp_load_rcfg", 8'(bus_if.reconfig_button), 8'h01);
    check("exp_load_expired", 8'(bus_if.expired), 8'h00);
    step();
    check("exp_load_idle", 8'(bus_if.state), 8'h00);
`endif

    // Clear, load 10, pause at prescaler 2, resume 20 cycles later.
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr0_trst", 8'(bus_if.timer_reset), 8'h01);
    check("clr0_state", 8'(bus_if.state), 8'h00);
    step();
    check("clr0_trst_off", 8'(bus_if.timer_reset), 8'h00);
    set_val = 8'h10;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("load10_rcfg", 8'(bus_if.reconfig_button), 8'h01);
    step();
    check("load10_idle", 8'(bus_if.state), 8'h00);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("p_start_running", 8'(bus_if.running), 8'h01);
    step();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("p_state", 8'(bus_if.state), 8'h03);
    check("p_running", 8'(bus_if.running), 8'h00);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("p_notick_%0d", i), 8'(bus_if.timer_decrement_1sec), 8'h00);
      check($sformatf("p_hold_%0d", i), 8'(bus_if.state), 8'h03);
      step();
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("resume_running", 8'(bus_if.running), 8'h01);
    check("resume_tick_c1", 8'(bus_if.timer_decrement_1sec), 8'h00);
    step();
    check("resume_tick_c2", 8'(bus_if.timer_decrement_1sec), 8'h01);
    step();
    for (int k = 3; k <= 6; k++) begin
      check($sformatf("resume_tick_c%0d", k), 8'(bus_if.timer_decrement_1sec),
            (k == 6) ? 8'h01 : 8'h00);
      step();
    end
    check("resume_digits", {m_hi, m_lo}, 8'h08);

    // Clear during RUN.
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_run_trst", 8'(bus_if.timer_reset), 8'h01);
    check("clr_run_running", 8'(bus_if.running), 8'h00);
    check("clr_run_state", 8'(bus_if.state), 8'h00);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("clr_run_notick_%0d", i), 8'(bus_if.timer_decrement_1sec), 8'h00);
      check($sformatf("clr_run_trst_off_%0d", i), 8'(bus_if.timer_reset), 8'h00);
    end

    // Start with digits 00 is ignored.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("zero_start_state", 8'(bus_if.state), 8'h00);
    check("zero_start_running", 8'(bus_if.running), 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("zero_start_notick_%0d", i), 8'(bus_if.timer_decrement_1sec), 8'h00);
    end

    // Load and start in the same cycle: load wins.
    set_val = 8'h05;
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check("ls_state", 8'(bus_if.state), 8'h01);
    check("ls_rcfg", 8'(bus_if.reconfig_button), 8'h01);
    check("ls_running", 8'(bus_if.running), 8'h00);
    step();
    check("ls_idle", 8'(bus_if.state), 8'h00);
    check("ls_rcfg_off", 8'(bus_if.reconfig_button), 8'h00);
    step();
    check("ls_still_idle", 8'(bus_if.state), 8'h00);

    // Asynchronous reset while a tick strobe is high.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_run_running", 8'(bus_if.running), 8'h01);
    repeat (3) step();
    check("rst_run_tick", 8'(bus_if.timer_decrement_1sec), 8'h01);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    check("post_rst_state", 8'(bus_if.state), 8'h00);
    check("post_rst_tick", 8'(bus_if.timer_decrement_1sec), 8'h00);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_controller.md
# countdown_controller

Sequencing controller for the two-digit BCD countdown timer. It turns user button pulses into the timer's control strobes: it generates the one-second decrement tick from `clk` and issues load (reconfigure) and clear strobes. It watches the timer's digit outputs for 00 and stops the count there with an expiry flag. It sits between the button debouncers and the two-digit timer instance.

## Interface
- `TICK_DIV`, default 50_000_000: `clk` cycles per decrement tick; must be ≥ 2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start_btn` in 1: single-cycle pulse (synchronized/debounced upstream); start or resume.
- `pause_btn` in 1: single-cycle pulse; pause a running count.
- `load_btn` in 1: single-cycle pulse; load set value into timer.
- `clear_btn` in 1: single-cycle pulse; abort and reset timer.
- `digit_lo` in 4: timer units digit (BCD).
- `digit_hi` in 4: timer tens digit (BCD).
- `timer_decrement_1sec` out 1: one-cycle decrement strobe to the timer.
- `reconfig_button` out 1: one-cycle load strobe to the timer.
- `timer_reset` out 1: one-cycle clear strobe to the timer.
- `running` out 1: high in RUN.
- `expired` out 1: high in EXPIRED.
- `state` out 3: current FSM state encoding (debug).

## Operation
- **States:** IDLE, LOAD, RUN, PAUSE, EXPIRED.
- **`zero`** = (`digit_hi`==0 && `digit_lo`==0).
- **Button priority in a cycle:** clear > load > pause > start. Lower-priority pulses in the same cycle are dropped.
- **clear_btn (any state):** `timer_reset`=1 for one cycle; prescaler cleared; next state IDLE.
- **load_btn:**
  - In IDLE, PAUSE or EXPIRED: next state LOAD.
  - In LOAD: `reconfig_button`=1 for exactly one cycle, prescaler cleared, then IDLE.
  - Ignored in RUN.
- **start_btn:**
  - In IDLE or PAUSE with !`zero`: next state RUN.
  - With `zero`: ignored.
  - Ignored in RUN and EXPIRED.
- **pause_btn:** RUN → PAUSE. Prescaler value is held, not cleared, so the partial second is kept.
- **RUN:**
  - Prescaler counts 0..`TICK_DIV`-1. On wrap it emits `timer_decrement_1sec`.
  - No tick is emitted when `zero`.
  - When `zero` is sampled true, go to EXPIRED.
  - The zero check is masked in the cycle immediately after a tick, while timer digits settle.
- **EXPIRED:** hold until clear_btn or load_btn. No ticks are issued.
- **Prescaler:** width = $clog2(`TICK_DIV`). It counts only in RUN, holds in PAUSE, and clears on LOAD, clear and expiry.

## Timing
- **Reset values:** all outputs 0; `state`=IDLE; prescaler 0.
- **Outputs:** all registered; strobes are exactly one cycle wide.
- **start:** start_btn at cycle n gives `running`=1 at n+1. The first tick comes at n+`TICK_DIV` (prescaler starts from 0 or from its held value).
- **Tick spacing:** exactly `TICK_DIV` cycles between ticks in uninterrupted RUN.
- **Expiry:** the last tick brings the digits to 00. `expired` asserts 2 cycles after that tick (1 masked cycle + 1 register).
- **Reset mid-operation:** returns immediately to IDLE, outputs cleared. Any in-flight strobe is truncated.

## Configuration
- **`CNTDN_AUTO_RELOAD_EN` defined:**
  - On expiry the FSM goes to LOAD, issuing `reconfig_button`.
  - It then returns directly to RUN instead of IDLE.
  - `expired` pulses high for one cycle only.
- **`CNTDN_AUTO_RELOAD_EN` undefined:** EXPIRED is terminal as described above. A manual load_btn still returns to IDLE.

## Structure
- **Package `countdown_pkg`:**
  - State enum (IDLE=0, LOAD=1, RUN=2, PAUSE=3, EXPIRED=4).
  - BCD zero constant.
  - State-width localparam.
- **Sub-module `tick_prescaler`:**
  - Parameter `TICK_DIV`.
  - Inputs `enable` and `clear`; output `tick`.
  - Instantiated once.
- **Top level:** FSM, button priority and output registers.

## Test plan
- `TICK_DIV`=4, digits 02, start → ticks at cycles 4 and 8 after start. Model decrements to 00; `expired`=1 two cycles after the second tick; no third tick.
- `TICK_DIV`=4, digits 10, start, pause at prescaler=2, resume 20 cycles later → next tick 2 cycles after resume. No tick during PAUSE.
- load_btn and start_btn in the same cycle from IDLE → LOAD wins: one `reconfig_button` pulse, back to IDLE, not RUN.
- clear_btn during RUN → `timer_reset` one-cycle pulse; `running`=0 next cycle; no further ticks.
- start with digits 00 → stays IDLE; no ticks. With `CNTDN_AUTO_RELOAD_EN`, expiry → `reconfig_button` pulse then RUN resumes.
- `rst` asserted mid-RUN → all outputs 0 asynchronously; `state`=IDLE.
